// File: rtl/mem_wb_latch.sv
// rtl/mem_wb_latch.sv - memory-stage request control and MEM/WB pipeline register
module mem_wb_latch #(
  parameter int WORD_W   = 32,
  parameter int REGSEL_W = 2,
  parameter int REGBIT_W = 5,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = $clog2(TIMEOUT + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ihit,
  input  logic                flush,
  input  logic                valid,
  input  logic                memRen,
  input  logic                memWen,
  input  logic [WORD_W-1:0]   nPC,
  input  logic [WORD_W-1:0]   ALUOut,
  input  logic [WORD_W-1:0]   storeData,
  input  logic                regWr,
  input  logic [REGSEL_W-1:0] regSel,
  input  logic [REGBIT_W-1:0] regDst,
  input  logic                dhit,
  input  logic [WORD_W-1:0]   dmemload,
  output logic                dmemREN,
  output logic                dmemWEN,
  output logic [WORD_W-1:0]   dmemaddr,
  output logic [WORD_W-1:0]   dmemstore,
  output logic                mem_stall,
  output logic [WORD_W-1:0]   nPC_next,
  output logic [WORD_W-1:0]   ALUOut_next,
  output logic [WORD_W-1:0]   dmemload_next,
  output logic                regWr_next,
  output logic                valid_next,
  output logic [REGSEL_W-1:0] regSel_next,
  output logic [REGBIT_W-1:0] regDst_next,
  output logic                mem_err
);

  // A zero timeout gives a zero-width counter; keep at least one bit.
  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                mem_err_q, mem_err_d;
  logic                aborted_q, aborted_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [WORD_W-1:0]   npc_q, npc_d;
  logic [WORD_W-1:0]   alu_q, alu_d;
  logic [WORD_W-1:0]   load_q, load_d;
  logic                regwr_q, regwr_d;
  logic                valid_q, valid_d;
  logic [REGSEL_W-1:0] regsel_q, regsel_d;
  logic [REGBIT_W-1:0] regdst_q, regdst_d;

  logic                access, not_done, abort, stall, advance, aborted;
  logic [WORD_W-1:0]   load_src;

  // Request, stall and FSM next state; dhit always wins over abort.
  always_comb begin
    access    = valid & (memRen | memWen);
    not_done  = (state_q != DONE);
    abort     = (TIMEOUT != 0) && (state_q == REQ) && (cnt_q == CNT_LAST) && !dhit;
    stall     = access & ~dhit & not_done & ~abort;
    advance   = ihit & ~stall;
    aborted   = abort | aborted_q;
    load_src  = aborted ? '0 : ((state_q == DONE) ? hold_q : dmemload);

    state_d   = state_q;
    aborted_d = aborted_q;
    hold_d    = hold_q;
    mem_err_d = mem_err_q | abort;
    cnt_d     = (state_q == REQ) ? cnt_q + CW'(1) : '0;

    if (dhit && not_done) hold_d = dmemload;

    case (state_q)
      IDLE: begin
        if (access && !dhit)             state_d = REQ;
        else if (access && dhit && !ihit) state_d = DONE;
      end
      REQ: begin
        if (dhit || abort) begin
          state_d = ihit ? IDLE : DONE;
          if (abort && !ihit) aborted_d = 1'b1;
        end
      end
      DONE: begin
        if (ihit) begin
          state_d   = IDLE;
          aborted_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // MEM/WB field update: flush beats advance, otherwise hold.
  always_comb begin
    npc_d    = npc_q;
    alu_d    = alu_q;
    load_d   = load_q;
    regwr_d  = regwr_q;
    valid_d  = valid_q;
    regsel_d = regsel_q;
    regdst_d = regdst_q;
    if (flush) begin
      npc_d    = '0;
      alu_d    = '0;
      load_d   = '0;
      regwr_d  = 1'b0;
      valid_d  = 1'b0;
      regsel_d = '0;
      regdst_d = '0;
    end else if (advance) begin
      npc_d    = nPC;
      alu_d    = ALUOut;
      load_d   = load_src;
      regwr_d  = regWr & ~aborted;
      valid_d  = valid;
      regsel_d = regSel;
      regdst_d = regDst;
    end
  end

  // All state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
      aborted_q <= 1'b0;
      hold_q    <= '0;
      npc_q     <= '0;
      alu_q     <= '0;
      load_q    <= '0;
      regwr_q   <= 1'b0;
      valid_q   <= 1'b0;
      regsel_q  <= '0;
      regdst_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
      aborted_q <= aborted_d;
      hold_q    <= hold_d;
      npc_q     <= npc_d;
      alu_q     <= alu_d;
      load_q    <= load_d;
      regwr_q   <= regwr_d;
      valid_q   <= valid_d;
      regsel_q  <= regsel_d;
      regdst_q  <= regdst_d;
    end
  end

  // Cache request is combinational and suppressed once the data is captured.
  always_comb begin
    dmemREN       = ~RST & access & memRen & not_done;
    dmemWEN       = ~RST & access & memWen & not_done;
    dmemaddr      = ALUOut;
    dmemstore     = storeData;
    mem_stall     = stall;
    nPC_next      = npc_q;
    ALUOut_next   = alu_q;
    dmemload_next = load_q;
    regWr_next    = regwr_q;
    valid_next    = valid_q;
    regSel_next   = regsel_q;
    regDst_next   = regdst_q;
    mem_err       = mem_err_q;
  end

endmodule

// File: tb/tb_mem_wb_latch.sv
// tb/tb_mem_wb_latch.sv - directed self-checking bench for mem_wb_latch
module tb_mem_wb_latch;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        ihit = 1'b0, flush = 1'b0, valid = 1'b0, memRen = 1'b0, memWen = 1'b0;
  logic [31:0] nPC = '0, ALUOut = '0, storeData = '0, dmemload = '0;
  logic        regWr = 1'b0, dhit = 1'b0;
  logic [1:0]  regSel = '0;
  logic [4:0]  regDst = '0;
  logic        dmemREN, dmemWEN, mem_stall, regWr_next, valid_next, mem_err;
  logic [31:0] dmemaddr, dmemstore, nPC_next, ALUOut_next, dmemload_next;
  logic [1:0]  regSel_next;
  logic [4:0]  regDst_next;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  mem_wb_latch #(.WORD_W(32), .REGSEL_W(2), .REGBIT_W(5), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .flush(flush), .valid(valid),
    .memRen(memRen), .memWen(memWen), .nPC(nPC), .ALUOut(ALUOut),
    .storeData(storeData), .regWr(regWr), .regSel(regSel), .regDst(regDst),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
    .nPC_next(nPC_next), .ALUOut_next(ALUOut_next), .dmemload_next(dmemload_next),
    .regWr_next(regWr_next), .valid_next(valid_next), .regSel_next(regSel_next),
    .regDst_next(regDst_next), .mem_err(mem_err)
  );

  typedef struct {
    logic        vld, ren, wen, ih, dh, rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] npc, alu, st, ld;
    logic        e_ren, e_wen, e_stall;
    logic [31:0] e_npc, e_ld;
    logic        e_rw, e_vld;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Quiet inputs with ihit low so the latched outputs hold.
  task automatic quiet();
    valid = 1'b0; memRen = 1'b0; memWen = 1'b0; dhit = 1'b0;
    flush = 1'b0; ihit = 1'b0; dmemload = '0;
  endtask

  task automatic load_req(input logic [31:0] addr, input logic [31:0] pc);
    valid = 1'b1; memRen = 1'b1; memWen = 1'b0; ALUOut = addr; nPC = pc;
    regWr = 1'b1; regSel = 2'd1; regDst = 5'd4; ihit = 1'b1; dhit = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1,1,0,1,1,1, 2'd1, 5'd3, 32'h104, 32'h100, 32'h0, 32'hDEADBEEF,
               1,0,0, 32'h104, 32'hDEADBEEF, 1,1, 5'd3};
    tbl[1] = '{1,0,1,1,1,0, 2'd0, 5'd0, 32'h108, 32'h180, 32'hCAFE0000, 32'h0,
               0,1,0, 32'h108, 32'h0, 0,1, 5'd0};
    tbl[2] = '{0,1,0,1,0,1, 2'd2, 5'd7, 32'h10C, 32'h1C0, 32'h0, 32'h55,
               0,0,0, 32'h10C, 32'h55, 1,0, 5'd7};
    tbl[3] = '{1,0,0,1,0,1, 2'd3, 5'd9, 32'h110, 32'h0, 32'h0, 32'hABCD,
               0,0,0, 32'h110, 32'hABCD, 1,1, 5'd9};
    tbl[4] = '{0,0,0,0,0,0, 2'd0, 5'd31, 32'h114, 32'h0, 32'h0, 32'h1111,
               0,0,0, 32'h110, 32'hABCD, 1,1, 5'd9};

    // Reset: request masked, everything cleared.
    valid = 1'b1; memRen = 1'b1; ALUOut = 32'h50;
    @(negedge CLK);
    chk("rst_dmemREN", 32'(dmemREN), 0);
    tick(); tick();
    chk("rst_valid_next", 32'(valid_next), 0);
    chk("rst_dmemload_next", dmemload_next, 0);
    chk("rst_nPC_next", nPC_next, 0);
    chk("rst_mem_err", 32'(mem_err), 0);
    quiet();
    RST = 1'b0;
    tick();

    // Single-cycle vectors from IDLE.
    for (int i = 0; i < 5; i++) begin
      valid = tbl[i].vld; memRen = tbl[i].ren; memWen = tbl[i].wen;
      ihit = tbl[i].ih; dhit = tbl[i].dh; regWr = tbl[i].rw;
      regSel = tbl[i].rs; regDst = tbl[i].rd; nPC = tbl[i].npc;
      ALUOut = tbl[i].alu; storeData = tbl[i].st; dmemload = tbl[i].ld;
      @(negedge CLK);
      chk($sformatf("v%0d_dmemREN", i), 32'(dmemREN), 32'(tbl[i].e_ren));
      chk($sformatf("v%0d_dmemWEN", i), 32'(dmemWEN), 32'(tbl[i].e_wen));
      chk($sformatf("v%0d_mem_stall", i), 32'(mem_stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_dmemaddr", i), dmemaddr, tbl[i].alu);
      chk($sformatf("v%0d_dmemstore", i), dmemstore, tbl[i].st);
      tick();
      chk($sformatf("v%0d_nPC_next", i), nPC_next, tbl[i].e_npc);
      chk($sformatf("v%0d_dmemload_next", i), dmemload_next, tbl[i].e_ld);
      chk($sformatf("v%0d_regWr_next", i), 32'(regWr_next), 32'(tbl[i].e_rw));
      chk($sformatf("v%0d_valid_next", i), 32'(valid_next), 32'(tbl[i].e_vld));
      chk($sformatf("v%0d_regDst_next", i), 32'(regDst_next), 32'(tbl[i].e_rd));
    end

    // Load miss: dhit in the third request cycle.
    load_req(32'h200, 32'h204);
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin dhit = 1'b1; dmemload = 32'h3333; end
      @(negedge CLK);
      chk($sformatf("miss_c%0d_stall", c), 32'(mem_stall), (c < 3) ? 1 : 0);
      chk($sformatf("miss_c%0d_dmemREN", c), 32'(dmemREN), 1);
      chk($sformatf("miss_c%0d_dmemaddr", c), dmemaddr, 32'h200);
      tick();
      if (c < 3) chk($sformatf("miss_c%0d_nPC_hold", c), nPC_next, 32'h110);
    end
    chk("miss_nPC_next", nPC_next, 32'h204);
    chk("miss_dmemload_next", dmemload_next, 32'h3333);
    quiet();
    tick();

    // Hit while ihit is low: captured value survives the bus changing.
    load_req(32'h240, 32'h244);
    ihit = 1'b0; dhit = 1'b1; dmemload = 32'h1234;
    @(negedge CLK);
    chk("hold_c1_dmemREN", 32'(dmemREN), 1);
    chk("hold_c1_stall", 32'(mem_stall), 0);
    tick();
    dhit = 1'b0; dmemload = 32'h0;
    @(negedge CLK);
    chk("hold_c2_dmemREN", 32'(dmemREN), 0);
    chk("hold_c2_stall", 32'(mem_stall), 0);
    tick();
    chk("hold_c2_dmemload_next", dmemload_next, 32'h3333);
    ihit = 1'b1;
    @(negedge CLK);
    chk("hold_c3_dmemREN", 32'(dmemREN), 0);
    tick();
    chk("hold_dmemload_next", dmemload_next, 32'h1234);
    chk("hold_nPC_next", nPC_next, 32'h244);
    chk("hold_regWr_next", 32'(regWr_next), 1);
    quiet();
    tick();

    // Flush while a miss is outstanding.
    load_req(32'h300, 32'h304);
    tick();
    flush = 1'b1;
    tick();
    chk("flush_valid_next", 32'(valid_next), 0);
    chk("flush_nPC_next", nPC_next, 0);
    chk("flush_dmemload_next", dmemload_next, 0);
    flush = 1'b0;
    @(negedge CLK);
    chk("flush_dmemREN_kept", 32'(dmemREN), 1);
    chk("flush_stall_kept", 32'(mem_stall), 1);
    tick();
    dhit = 1'b1; dmemload = 32'h77;
    tick();
    chk("flush_done_dmemload_next", dmemload_next, 32'h77);
    chk("flush_done_valid_next", 32'(valid_next), 1);
    quiet();
    tick();

    // Timeout with no dhit: four stall cycles then abort.
    load_req(32'h400, 32'h404);
    dmemload = 32'h9999;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      chk($sformatf("to_c%0d_stall", c), 32'(mem_stall), (c < 5) ? 1 : 0);
      chk($sformatf("to_c%0d_mem_err", c), 32'(mem_err), 0);
      tick();
    end
    chk("to_mem_err", 32'(mem_err), 1);
    chk("to_regWr_next", 32'(regWr_next), 0);
    chk("to_dmemload_next", dmemload_next, 0);
    chk("to_valid_next", 32'(valid_next), 1);
    quiet();
    tick(); tick();
    chk("to_mem_err_sticky", 32'(mem_err), 1);
    load_req(32'h440, 32'h444);
    dhit = 1'b1; dmemload = 32'h4444;
    tick();
    chk("to_after_regWr_next", 32'(regWr_next), 1);
    chk("to_after_dmemload_next", dmemload_next, 32'h4444);
    chk("to_after_mem_err", 32'(mem_err), 1);
    quiet();
    tick();

    // Reset in the middle of a request.
    load_req(32'h500, 32'h504);
    tick();
    RST = 1'b1;
    @(negedge CLK);
    chk("rstreq_dmemREN", 32'(dmemREN), 0);
    tick();
    chk("rstreq_mem_err", 32'(mem_err), 0);
    chk("rstreq_valid_next", 32'(valid_next), 0);
    chk("rstreq_nPC_next", nPC_next, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rstreq_idle_dmemREN", 32'(dmemREN), 1);
    chk("rstreq_idle_stall", 32'(mem_stall), 1);
    tick();
    dhit = 1'b1; dmemload = 32'hE0;
    tick();
    chk("rstreq_done_dmemload_next", dmemload_next, 32'hE0);
    quiet();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
